fetch_unit: RTL and testbench

Parametrised instruction-fetch front end that replaces the single-cycle PC/imem fetch with a decoupled, latency-tolerant design. It issues requests to an instruction memory over a valid/ready request channel and accepts in-order responses after a variable latency. Fetched instructions are buffered with their PCs in a FIFO fetch queue, presented to decode through a valid/ready handshake. It supports redirect (branch/jump/exception) with queue flush and discard of in-flight responses.

---
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Decoupled instruction fetch front end with in-flight PC tracking,
//             a {pc, instr} fetch queue and redirect with stale-response drop.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic [31:0]     out_instr
);

  localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pcf_q [FQ_DEPTH];
  logic [XLEN-1:0] pcf_d [FQ_DEPTH];
  logic [PW-1:0]   pcf_wr_q, pcf_wr_d, pcf_rd_q, pcf_rd_d;
  logic [XLEN-1:0] fq_pc_q [FQ_DEPTH];
  logic [XLEN-1:0] fq_pc_d [FQ_DEPTH];
  logic [31:0]     fq_instr_q [FQ_DEPTH];
  logic [31:0]     fq_instr_d [FQ_DEPTH];
  logic [PW-1:0]   fq_wr_q, fq_wr_d, fq_rd_q, fq_rd_d;
  logic [CW-1:0]   fq_count_q, fq_count_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [CW:0]     credit_used;
  logic            req_fire, rsp_eff, rsp_drop, rsp_keep, out_fire;
  logic            unused_redirect_lsbs;

  // Credits cover both queued and in-flight entries, so a response always has a slot.
  assign credit_used    = {1'b0, fq_count_q} + {1'b0, inflight_q};
  assign imem_req_valid = !reset && !redirect_valid && (credit_used < (CW+1)'(FQ_DEPTH));
  assign imem_req_addr  = fetch_pc_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_eff  = imem_rsp_valid && (inflight_q != '0);
  assign rsp_drop = rsp_eff && (drop_cnt_q != '0);
  assign rsp_keep = rsp_eff && (drop_cnt_q == '0);
  assign out_fire = out_valid && out_ready;

  assign out_valid    = (fq_count_q != '0);
  assign out_pc       = fq_pc_q[fq_rd_q];
  assign out_pc_plus4 = out_pc + XLEN'(4);
  assign out_instr    = fq_instr_q[fq_rd_q];

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pcf_d      = pcf_q;
    pcf_wr_d   = pcf_wr_q;
    pcf_rd_d   = pcf_rd_q;
    fq_pc_d    = fq_pc_q;
    fq_instr_d = fq_instr_q;
    fq_wr_d    = fq_wr_q;
    fq_rd_d    = fq_rd_q;
    fq_count_d = fq_count_q;
    inflight_d = inflight_q;
    drop_cnt_d = drop_cnt_q;

    if (redirect_valid) begin
      // Everything still outstanding becomes stale, minus a response landing now.
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      pcf_wr_d   = '0;
      pcf_rd_d   = '0;
      fq_wr_d    = '0;
      fq_rd_d    = '0;
      fq_count_d = '0;
      inflight_d = inflight_q - CW'(rsp_eff);
      drop_cnt_d = inflight_q - CW'(rsp_eff);
    end else begin
      if (req_fire) begin
        fetch_pc_d      = fetch_pc_q + XLEN'(4);
        pcf_d[pcf_wr_q] = fetch_pc_q;
        pcf_wr_d        = pcf_wr_q + PW'(1);
      end
      if (rsp_keep) begin
        fq_pc_d[fq_wr_q]    = pcf_q[pcf_rd_q];
        fq_instr_d[fq_wr_q] = imem_rsp_data;
        fq_wr_d             = fq_wr_q + PW'(1);
        pcf_rd_d            = pcf_rd_q + PW'(1);
      end
      if (out_fire) begin
        fq_rd_d = fq_rd_q + PW'(1);
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      fq_count_d = fq_count_q + CW'(rsp_keep) - CW'(out_fire);
      inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_eff);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      pcf_q      <= '{default: '0};
      pcf_wr_q   <= '0;
      pcf_rd_q   <= '0;
      fq_pc_q    <= '{default: '0};
      fq_instr_q <= '{default: '0};
      fq_wr_q    <= '0;
      fq_rd_q    <= '0;
      fq_count_q <= '0;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pcf_q      <= pcf_d;
      pcf_wr_q   <= pcf_wr_d;
      pcf_rd_q   <= pcf_rd_d;
      fq_pc_q    <= fq_pc_d;
      fq_instr_q <= fq_instr_d;
      fq_wr_q    <= fq_wr_d;
      fq_rd_q    <= fq_rd_d;
      fq_count_q <= fq_count_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Directed self-checking bench for fetch_unit with an in-order
//             variable-latency instruction memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  localparam int          XLEN     = 32;
  localparam int          FQ_DEPTH = 4;
  localparam logic [31:0] MAGIC    = 32'hDEAD_BEEF;

  logic            clk;
  logic            reset;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_plus4;
  logic [31:0]     out_instr;

  fetch_unit #(
    .XLEN    (XLEN),
    .RESET_PC(32'h0000_0100),
    .FQ_DEPTH(FQ_DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_pc_plus4  (out_pc_plus4),
    .out_instr     (out_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] addr; int cyc; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic [31:0] pc4; int cyc; } out_t;

  mreq_t memq[$];
  req_t  req_log[$];
  out_t  out_log[$];

  int cyc;
  int lat;
  bit rand_mode;
  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic tick();
    logic  rf, of;
    req_t  r;
    out_t  o;
    mreq_t m;
    int    l;
    if (rand_mode) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      out_ready      = 1'($urandom_range(0, 1));
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memq[0].addr ^ MAGIC;
    end
    #1;
    rf = imem_req_valid && imem_req_ready;
    of = out_valid && out_ready;
    if (rf) begin
      r.addr = imem_req_addr;
      r.cyc  = cyc;
      req_log.push_back(r);
    end
    if (of) begin
      o.pc    = out_pc;
      o.instr = out_instr;
      o.pc4   = out_pc_plus4;
      o.cyc   = cyc;
      out_log.push_back(o);
    end
    @(posedge clk);
    if (imem_rsp_valid) void'(memq.pop_front());
    if (rf) begin
      l      = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
      m.addr = r.addr;
      m.due  = cyc + l;
      memq.push_back(m);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    rand_mode      = 1'b0;
    memq.delete();
    run(2);
    reset = 1'b0;
    req_log.delete();
    out_log.delete();
  endtask

  int r_cyc;
  int c0;

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; lat = 1; rand_mode = 1'b0;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; out_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    @(negedge clk);

    // Reset state
    run(2);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr",  imem_req_addr,  32'h100);
    chk("rst_out_valid", out_valid,      0);
    chk("rst_out_pc",    out_pc,         0);
    chk("rst_out_pc4",   out_pc_plus4,   4);
    chk("rst_out_instr", out_instr,      0);

    // Streaming at L=1
    lat = 1;
    do_reset();
    c0 = cyc;
    run(8);
    chk("t1_nreq", req_log.size(), 8);
    if (req_log.size() >= 4) begin
      chk("t1_first_req_cyc", req_log[0].cyc, c0);
      for (int i = 0; i < 4; i++) chk("t1_req_addr", req_log[i].addr, 32'h100 + 4 * i);
    end
    chk("t1_nout", out_log.size(), 6);
    if (out_log.size() >= 6) begin
      chk("t1_first_out_lat", out_log[0].cyc - c0, 2);
      for (int i = 0; i < 6; i++) begin
        chk("t1_out_pc",    out_log[i].pc,    32'h100 + 4 * i);
        chk("t1_out_instr", out_log[i].instr, (32'h100 + 4 * i) ^ MAGIC);
      end
    end

    // Back-pressure fills the queue exactly
    do_reset();
    out_ready = 1'b0;
    run(10);
    chk("t2_nreq",          req_log.size(), 4);
    chk("t2_out_valid",     out_valid,      1);
    chk("t2_req_valid",     imem_req_valid, 0);
    out_ready = 1'b1;
    run(8);
    chk("t2_nout_ge6", out_log.size() >= 6, 1);
    if (out_log.size() >= 6)
      for (int i = 0; i < 6; i++) chk("t2_out_pc", out_log[i].pc, 32'h100 + 4 * i);

    // Redirect with three requests in flight, none answered yet
    do_reset();
    lat = 4;
    run(3);
    req_log.delete();
    out_log.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2000;
    r_cyc = cyc;
    tick();
    redirect_valid = 1'b0;
    chk("t3_no_req_in_redirect", req_log.size(), 0);
    run(10);
    chk("t3_req_seen", req_log.size() > 0, 1);
    if (req_log.size() > 0) begin
      chk("t3_req_addr", req_log[0].addr, 32'h2000);
      chk("t3_req_cyc",  req_log[0].cyc,  r_cyc + 1);
    end
    chk("t3_nout_ge2", out_log.size() >= 2, 1);
    if (out_log.size() >= 2) begin
      chk("t3_out_pc",    out_log[0].pc,    32'h2000);
      chk("t3_out_instr", out_log[0].instr, 32'h2000 ^ MAGIC);
      chk("t3_out_pc4",   out_log[0].pc4,   32'h2004);
      chk("t3_out_cyc",   out_log[0].cyc,   r_cyc + 6);
      chk("t3_out_pc_2",  out_log[1].pc,    32'h2004);
    end

    // Redirect coinciding with a response and an out handshake (L=2)
    do_reset();
    lat = 2;
    run(3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3000;
    r_cyc = cyc;
    tick();
    redirect_valid = 1'b0;
    run(6);
    chk("t4_nout", out_log.size(), 4);
    if (out_log.size() >= 3) begin
      chk("t4_consumed_pc",  out_log[0].pc,    32'h100);
      chk("t4_consumed_cyc", out_log[0].cyc,   r_cyc);
      chk("t4_new_pc",       out_log[1].pc,    32'h3000);
      chk("t4_new_instr",    out_log[1].instr, 32'h3000 ^ MAGIC);
      chk("t4_new_cyc",      out_log[1].cyc,   r_cyc + 4);
      chk("t4_next_pc",      out_log[2].pc,    32'h3004);
    end

    // Random ready and latency 1..4
    do_reset();
    lat = 0;
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      chk("t5_credit", (req_log.size() - out_log.size()) <= FQ_DEPTH, 1);
    end
    rand_mode      = 1'b0;
    imem_req_ready = 1'b0;
    out_ready      = 1'b1;
    run(20);
    chk("t5_progress", out_log.size() > 20, 1);
    chk("t5_no_loss",  out_log.size(), req_log.size());
    for (int i = 0; i < out_log.size(); i++) begin
      chk("t5_out_pc",    out_log[i].pc,    32'h100 + 4 * i);
      chk("t5_out_instr", out_log[i].instr, (32'h100 + 4 * i) ^ MAGIC);
    end

    // Address wrap at the top of the space
    do_reset();
    lat = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    r_cyc = cyc;
    tick();
    redirect_valid = 1'b0;
    run(5);
    chk("t6_nreq_ge2", req_log.size() >= 2, 1);
    if (req_log.size() >= 2) begin
      chk("t6_req0_addr", req_log[0].addr, 32'hFFFF_FFFC);
      chk("t6_req0_cyc",  req_log[0].cyc,  r_cyc + 1);
      chk("t6_req1_addr", req_log[1].addr, 32'h0);
    end
    chk("t6_nout_ge2", out_log.size() >= 2, 1);
    if (out_log.size() >= 2) begin
      chk("t6_out0_pc",  out_log[0].pc,  32'hFFFF_FFFC);
      chk("t6_out0_pc4", out_log[0].pc4, 32'h0);
      chk("t6_out0_cyc", out_log[0].cyc, r_cyc + 3);
      chk("t6_out1_pc",  out_log[1].pc,  32'h0);
    end

    // Back-to-back redirects; the last one wins and its low bits are dropped
    redirect_valid = 1'b1;
    redirect_pc    = 32'h500;
    tick();
    req_log.delete();
    out_log.delete();
    redirect_pc = 32'h103;
    r_cyc = cyc;
    tick();
    redirect_valid = 1'b0;
    run(5);
    chk("t7_req_seen", req_log.size() > 0, 1);
    if (req_log.size() > 0) begin
      chk("t7_req_addr", req_log[0].addr, 32'h100);
      chk("t7_req_cyc",  req_log[0].cyc,  r_cyc + 1);
    end
    chk("t7_out_seen", out_log.size() > 0, 1);
    if (out_log.size() > 0) begin
      chk("t7_out_pc",    out_log[0].pc,    32'h100);
      chk("t7_out_instr", out_log[0].instr, 32'h100 ^ MAGIC);
      chk("t7_out_cyc",   out_log[0].cyc,   r_cyc + 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
